// File: rtl/ad7276_serial_rx.sv
// AD7276 serial capture: drives cs_n/sclk, shifts in 16 bits per conversion, emits 12-bit samples on AXI-Stream.
// Optional frame marking (m_axis_tlast + FRAME_LEN sample counter) is enabled by defining AD7276_TLAST_EN.
module ad7276_serial_rx #(
    parameter int DIV_WIDTH    = 4,
    parameter int QUIET_CYCLES = 4,
    parameter int FRAME_LEN    = 256
) (
    input  logic                 clk_in,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_ctrl,
    input  logic                 sdata,
    output logic                 sclk,
    output logic                 cs_n,
    output logic [15:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
`ifdef AD7276_TLAST_EN
    output logic                 m_axis_tlast,
`endif
    output logic                 overrun
);

    localparam int              QW         = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [QW-1:0]   QUIET_LAST = QW'(QUIET_CYCLES - 1);
    localparam logic [5:0]      LAST_EDGE  = 6'd32;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        QUIET
    } state_t;

    state_t               state_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] half_cnt_q;
    logic [5:0]           edge_cnt_q;
    logic [QW-1:0]        quiet_cnt_q;
    logic [15:0]          shift_q;
    logic                 sclk_q;
    logic                 cs_n_q;
    logic                 tvalid_q;
    logic [15:0]          tdata_q;
    logic                 overrun_q;

    logic                 conv_done;
    logic                 handshake;
    logic                 accept;
    logic [15:0]          result;
    logic                 unused_pad_bits;

    // The 32nd sclk edge has already been driven; this cycle closes the conversion.
    assign conv_done = (state_q == CONV) && (edge_cnt_q == LAST_EDGE);
    assign handshake = tvalid_q && m_axis_tready;
    assign accept    = conv_done && (!tvalid_q || m_axis_tready);

    // Two leading zeros and two trailing pad bits surround the 12-bit sample.
    assign result          = {4'h0, shift_q[13:2]};
    assign unused_pad_bits = ^{shift_q[15:14], shift_q[1:0]};

    // NOTE: sequential state is written with <= so every register sees pre-edge values.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            div_q       <= '0;
            half_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            quiet_cnt_q <= '0;
            shift_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q    <= CONV;
                        cs_n_q     <= 1'b0;
                        div_q      <= div_ctrl;
                        half_cnt_q <= '0;
                        edge_cnt_q <= '0;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        state_q     <= QUIET;
                        cs_n_q      <= 1'b1;
                        quiet_cnt_q <= '0;
                    end else if (half_cnt_q == div_q) begin
                        half_cnt_q <= '0;
                        sclk_q     <= !sclk_q;
                        edge_cnt_q <= edge_cnt_q + 6'd1;
                        // Capture on the cycle that drives sclk high; the ADC updated sdata on the prior fall.
                        if (!sclk_q) begin
                            shift_q <= {shift_q[14:0], sdata};
                        end
                    end else begin
                        half_cnt_q <= half_cnt_q + DIV_WIDTH'(1);
                    end
                end
                QUIET: begin
                    if (quiet_cnt_q == QUIET_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        quiet_cnt_q <= quiet_cnt_q + QW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output holding register: a result arriving while the old one is stuck is dropped.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= conv_done && !accept;
            if (accept) begin
                tvalid_q <= 1'b1;
                tdata_q  <= result;
            end else if (handshake) begin
                tvalid_q <= 1'b0;
            end
        end
    end

`ifdef AD7276_TLAST_EN
    localparam int            FW         = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

    logic [FW-1:0] frame_cnt_q;
    logic [FW-1:0] frame_cnt_d;
    logic          tlast_q;

    // Counts delivered samples only; the count including a same-cycle handshake tags the incoming sample.
    // NOTE: frame_cnt_d gets a default first so no path through the block infers a latch.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (handshake) begin
            frame_cnt_d = tlast_q ? '0 : frame_cnt_q + FW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
            tlast_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            if (accept) begin
                tlast_q <= (frame_cnt_d == FRAME_LAST);
            end else if (handshake) begin
                tlast_q <= 1'b0;
            end
        end
    end

    assign m_axis_tlast = tlast_q;
`else
    localparam int unused_frame_len = FRAME_LEN;
`endif

    assign sclk          = sclk_q;
    assign cs_n          = cs_n_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_ad7276_serial_rx.sv
// Bench for ad7276_serial_rx: behavioural ADC plus stream scoreboard, directed scenarios and a randomized run.
// Build with AD7276_TLAST_EN defined to also exercise the frame-marking option.
module tb_ad7276_serial_rx;

    localparam int DIV_WIDTH    = 4;
    localparam int QUIET_CYCLES = 4;
    localparam int FRAME_LEN    = 4;

    logic                 clk_in = 1'b0;
    logic                 rstn = 1'b0;
    logic                 en = 1'b0;
    logic [DIV_WIDTH-1:0] div_ctrl = '0;
    logic                 sdata = 1'b0;
    logic                 m_axis_tready = 1'b0;
    logic                 sclk;
    logic                 cs_n;
    logic [15:0]          m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 overrun;
`ifdef AD7276_TLAST_EN
    logic                 m_axis_tlast;
`endif

    ad7276_serial_rx #(
        .DIV_WIDTH   (DIV_WIDTH),
        .QUIET_CYCLES(QUIET_CYCLES),
        .FRAME_LEN   (FRAME_LEN)
    ) dut (
        .clk_in       (clk_in),
        .rstn         (rstn),
        .en           (en),
        .div_ctrl     (div_ctrl),
        .sdata        (sdata),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
`ifdef AD7276_TLAST_EN
        .m_axis_tlast (m_axis_tlast),
`endif
        .overrun      (overrun)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC model and scoreboard state, all observed on the falling clk_in edge.
    logic [15:0]          adc_q[$];
    logic                 tlast_log[$];
    logic [15:0]          cur_word = '0;
    logic [DIV_WIDTH-1:0] prev_div = '0;
    logic                 prev_cs = 1'b1;
    logic                 prev_sclk = 1'b1;
    logic                 hs_prev = 1'b0;
    logic                 m_valid = 1'b0;
    logic [15:0]          m_data = '0;
    logic                 exp_ovr;
    logic                 done_ev;
    logic                 hs_ev;
    int                   conv_start = 0;
    int                   conv_h = 1;
    int                   n_fall = 0;
    int                   n_rise = 0;
    int                   n_done = 0;
    int                   n_ovr = 0;
    int                   n_hs = 0;
    int                   n_deliv = 0;

    always @(negedge clk_in) begin
        if (!rstn) begin
            m_valid   = 1'b0;
            m_data    = '0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b1;
            hs_prev   = 1'b0;
            n_deliv   = 0;
            sdata     = 1'b0;
        end else begin
            hs_ev   = hs_prev;
            done_ev = !prev_cs && cs_n;
            if (prev_cs && !cs_n) begin
                conv_start = cyc;
                conv_h     = int'(prev_div) + 1;
                n_fall     = 0;
                n_rise     = 0;
                cur_word   = (adc_q.size() > 0) ? adc_q.pop_front() : 16'($urandom);
                sdata      = cur_word[15];
            end else if (!cs_n) begin
                if (prev_sclk && !sclk) begin
                    n_fall++;
                    check("sclk_fall_time", 32'(cyc - conv_start), 32'(conv_h * (2 * n_fall - 1)));
                    sdata = (n_fall <= 16) ? cur_word[16 - n_fall] : 1'b0;
                end
                if (!prev_sclk && sclk) begin
                    n_rise++;
                    check("sclk_rise_time", 32'(cyc - conv_start), 32'(2 * conv_h * n_rise));
                end
            end else begin
                check("sclk_idle_high", 32'(sclk), 32'd1);
            end
            if (done_ev) begin
                n_done++;
                check("conv_falls", 32'(n_fall), 32'd16);
                check("conv_rises", 32'(n_rise), 32'd16);
                check("conv_latency", 32'(cyc - conv_start), 32'(32 * conv_h + 1));
            end
            exp_ovr = 1'b0;
            if (done_ev && (!m_valid || hs_ev)) begin
                m_valid = 1'b1;
                m_data  = {4'h0, cur_word[13:2]};
            end else if (done_ev) begin
                exp_ovr = 1'b1;
            end else if (hs_ev) begin
                m_valid = 1'b0;
            end
            check("tvalid", 32'(m_axis_tvalid), 32'(m_valid));
            if (m_valid) check("tdata", 32'(m_axis_tdata), 32'(m_data));
            check("overrun", 32'(overrun), 32'(exp_ovr));
            if (overrun) n_ovr++;
            hs_prev = m_axis_tvalid && m_axis_tready;
            if (hs_prev) begin
                n_hs++;
`ifdef AD7276_TLAST_EN
                check("tlast", 32'(m_axis_tlast), 32'((n_deliv % FRAME_LEN) == FRAME_LEN - 1));
                tlast_log.push_back(m_axis_tlast);
`endif
                n_deliv++;
            end
            prev_cs   = cs_n;
            prev_sclk = sclk;
        end
        prev_div = div_ctrl;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wait_cs(input logic val, input int bound, input string tag);
        int k = 0;
        while (cs_n !== val && k < bound) begin
            tick();
            k++;
        end
        check(tag, 32'(cs_n), 32'(val));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d, expected under 90000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t_fall;
        int          t_rise;
        int          base;
        int          base_ovr;
        int          pulses;
        int          lows;
        int          edges;
        int          seen;
        int          k;
        logic [15:0] w1;
        logic [15:0] w2;
        logic        sclk_prev;

        // Reset values
        tick(3);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd1);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);

        // Known pattern at H=2: result, latency and quiet gap
        div_ctrl      = 4'd1;
        m_axis_tready = 1'b1;
        adc_q.push_back(16'h2B34);
        rstn = 1'b1;
        en   = 1'b1;
        wait_cs(1'b0, 10, "a_cs_fall");
        t_fall = cyc;
        k = 0;
        while (!m_axis_tvalid && k < 200) begin
            tick();
            k++;
        end
        check("a_latency", 32'(cyc - t_fall), 32'd65);
        check("a_tdata", 32'(m_axis_tdata), 32'h0ACD);
        check("a_cs_high", 32'(cs_n), 32'd1);
        t_rise = cyc;
        wait_cs(1'b0, 20, "a_cs_refall");
        check("a_quiet_gap", 32'(cyc - t_rise), 32'(QUIET_CYCLES + 1));
        en = 1'b0;
        wait_cs(1'b1, 200, "a_drain");
        tick(QUIET_CYCLES + 2);

        // H=1: sixteen single-cycle sclk low pulses
        div_ctrl = 4'd0;
        en       = 1'b1;
        wait_cs(1'b0, 10, "b_cs_fall");
        en        = 1'b0;
        pulses    = 0;
        lows      = 0;
        k         = 0;
        sclk_prev = sclk;
        while (cs_n == 1'b0 && k < 100) begin
            tick();
            k++;
            if (!sclk) lows++;
            if (sclk_prev && !sclk) pulses++;
            sclk_prev = sclk;
        end
        check("b_low_pulses", 32'(pulses), 32'd16);
        check("b_low_cycles", 32'(lows), 32'd16);
        check("b_cs_rise", 32'(cs_n), 32'd1);
        tick(QUIET_CYCLES + 2);

        // Stalled sink across two conversions
        m_axis_tready = 1'b0;
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        adc_q.push_back(w1);
        adc_q.push_back(w2);
        base     = n_done;
        base_ovr = n_ovr;
        en       = 1'b1;
        k = 0;
        while (n_done < base + 2 && k < 300) begin
            tick();
            k++;
        end
        en = 1'b0;
        check("c_two_done", 32'(n_done - base), 32'd2);
        check("c_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        check("c_tdata_first", 32'(m_axis_tdata), 32'({4'h0, w1[13:2]}));
        check("c_overrun_once", 32'(n_ovr - base_ovr), 32'd1);
        m_axis_tready = 1'b1;
        tick();
        check("c_tvalid_cleared", 32'(m_axis_tvalid), 32'd0);
        tick(QUIET_CYCLES + 2);

        // Reset at the 8th sclk rising edge
        div_ctrl = 4'd2;
        en       = 1'b1;
        wait_cs(1'b0, 10, "d_cs_fall");
        edges     = 0;
        k         = 0;
        sclk_prev = sclk;
        while (edges < 8 && k < 200) begin
            tick();
            k++;
            if (!sclk_prev && sclk) edges++;
            sclk_prev = sclk;
        end
        check("d_reached_8th_rise", 32'(edges), 32'd8);
        rstn = 1'b0;
        en   = 1'b0;
        #1;
        check("d_rst_cs_n", 32'(cs_n), 32'd1);
        check("d_rst_sclk", 32'(sclk), 32'd1);
        check("d_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        tick(3);
        rstn = 1'b1;
        seen = 0;
        lows = 0;
        repeat (60) begin
            tick();
            if (m_axis_tvalid) seen++;
            if (!cs_n) lows++;
        end
        check("d_no_tvalid", 32'(seen), 32'd0);
        check("d_cs_stays_high", 32'(lows), 32'd0);

        // en dropped at the 3rd sclk edge
        div_ctrl = 4'd1;
        en       = 1'b1;
        wait_cs(1'b0, 10, "e_cs_fall");
        base      = n_hs;
        edges     = 0;
        k         = 0;
        sclk_prev = sclk;
        while (edges < 3 && k < 100) begin
            tick();
            k++;
            if (sclk_prev != sclk) edges++;
            sclk_prev = sclk;
        end
        en = 1'b0;
        check("e_reached_3rd_edge", 32'(edges), 32'd3);
        wait_cs(1'b1, 200, "e_cs_rise");
        lows = 0;
        repeat (60) begin
            tick();
            if (!cs_n) lows++;
        end
        check("e_cs_stays_high", 32'(lows), 32'd0);
        check("e_one_sample", 32'(n_hs - base), 32'd1);

        // Randomized run: div_ctrl churns every cycle, sink alternates between jittery and stalled
        base     = n_done;
        base_ovr = n_ovr;
        en       = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            div_ctrl      = DIV_WIDTH'($urandom_range(0, 3));
            m_axis_tready = (((i / 400) % 2) == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        en            = 1'b0;
        m_axis_tready = 1'b1;
        wait_cs(1'b1, 200, "f_drain");
        tick(QUIET_CYCLES + 2);
        check("f_progress", 32'((n_done - base) >= 20), 32'd1);
        check("f_overruns_seen", 32'(n_ovr > base_ovr), 32'd1);

`ifdef AD7276_TLAST_EN
        // Frame marking with FRAME_LEN=4 and an always-ready sink
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tlast_log.delete();
        div_ctrl      = 4'd0;
        m_axis_tready = 1'b1;
        base          = n_hs;
        en            = 1'b1;
        k = 0;
        while (n_hs - base < 8 && k < 1000) begin
            tick();
            k++;
        end
        en = 1'b0;
        check("g_eight_samples", 32'((n_hs - base) >= 8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < tlast_log.size()) begin
                check($sformatf("g_tlast_%0d", i), 32'(tlast_log[i]), 32'((i == 3) || (i == 7)));
            end
        end
        wait_cs(1'b1, 200, "g_drain");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad7276_serial_rx.md
AD7276_SERIAL_RX -- requirements
Module: ad7276_serial_rx

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 4, which sets the width of div_ctrl.
REQ-002 SHALL have parameter QUIET_CYCLES, default 4, the number of clk_in cycles cs_n stays high after each conversion.
REQ-003 SHALL have parameter FRAME_LEN, default 256, the samples per frame (used only when AD7276_TLAST_EN is defined).
REQ-004 SHALL have port clk_in, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: continuous-conversion enable.
REQ-007 SHALL have port div_ctrl, input, DIV_WIDTH bits: sets the SCLK half-period to H = div_ctrl+1 clk_in cycles.
REQ-008 SHALL have port sdata, input, 1 bit: ADC serial data out.
REQ-009 SHALL have port sclk, output, 1 bit: ADC serial clock, registered, idling high.
REQ-010 SHALL have port cs_n, output, 1 bit: ADC chip select, registered, active low.
REQ-011 SHALL have port m_axis_tdata, output, 16 bits: the 12-bit sample zero-extended in [11:0].
REQ-012 SHALL have port m_axis_tvalid, output, 1 bit: AXI-Stream valid.
REQ-013 SHALL have port m_axis_tready, input, 1 bit: AXI-Stream ready.
REQ-014 SHALL have port overrun, output, 1 bit: one-cycle pulse when a sample is dropped.
REQ-015 SHALL have port m_axis_tlast, output, 1 bit, present only with AD7276_TLAST_EN.

Function
REQ-016 SHALL implement a state machine with states IDLE, CONV and QUIET.
REQ-017 SHALL transition IDLE->CONV when en=1: cs_n drives low and div_ctrl is latched; div_ctrl changes during CONV SHALL have no effect.
REQ-018 SHALL, in CONV, toggle sclk every H cycles: the first falling edge comes H cycles after cs_n falls, followed by exactly 16 falling and 16 rising edges.
REQ-019 SHALL sample sdata in the clk_in cycle that drives each sclk rising edge, shifting MSB first into a 16-bit register.
REQ-020 SHALL take sample bits [13:2] of the 16-bit shift register (two leading zeros, two trailing) as the 12-bit result.
REQ-021 SHALL drive cs_n high and enter QUIET on the cycle after the 16th rising edge; QUIET SHALL last QUIET_CYCLES cycles and then go to IDLE.
REQ-022 SHALL present the result on the cycle QUIET is entered: tvalid rises 32*H+1 cycles after cs_n falls.
REQ-023 SHALL hold tdata and tvalid stable until tvalid && tready; the handshake SHALL clear tvalid unless a new result lands in the same cycle, in which case tvalid stays high with the new data.
REQ-024 SHALL, when a result completes while tvalid=1 and tready=0, discard the new result, keep the old one, and pulse overrun high for 1 cycle.
REQ-025 SHALL finish a conversion in progress when en drops mid-CONV (result delivered), then remain in IDLE.
REQ-026 SHALL keep sclk high whenever cs_n is high.
REQ-027 SHALL, with div_ctrl=0 (H=1), toggle sclk every clk_in cycle with no skipped or extra edges.

Reset
REQ-028 SHALL, on rstn low, immediately and asynchronously set cs_n=1, sclk=1, tvalid=0, overrun=0, tdata=0, state=IDLE, counters=0, and tlast=0 when present.
REQ-029 SHALL abandon any conversion when reset is asserted mid-CONV and produce no partial sample.
REQ-030 SHALL start the first conversion no earlier than the first clk_in edge after rstn deasserts with en=1.

Configuration
REQ-031 SHALL, with macro AD7276_TLAST_EN defined, add m_axis_tlast and a sample counter.
REQ-032 SHALL, with AD7276_TLAST_EN, assert tlast with the FRAME_LEN-th delivered sample; dropped samples SHALL not count, and the counter wraps to 0 after that handshake.
REQ-033 SHALL, without AD7276_TLAST_EN, have no tlast port and no frame counter, with all other behaviour identical.

Verification
REQ-034 SHALL cover: div_ctrl=1, QUIET_CYCLES=4, sdata pattern 0b0010_1011_0011_0100 -> tdata=0x0ACD, tvalid rises 65 cycles after cs_n falls, next cs_n fall 5 cycles after cs_n rise.
REQ-035 SHALL cover: div_ctrl=0 -> exactly 16 sclk low pulses, each 1 cycle wide, while cs_n is low.
REQ-036 SHALL cover: tready=0 across two conversions -> first sample retained, overrun pulses once, tdata unchanged.
REQ-037 SHALL cover: rstn low at the 8th sclk rising edge -> cs_n=1 and sclk=1 within the same cycle, no tvalid after reset is released with en=0.
REQ-038 SHALL cover: en dropped at the 3rd sclk edge -> one sample delivered, cs_n stays high afterward.
REQ-039 SHALL cover: AD7276_TLAST_EN, FRAME_LEN=4, tready=1 -> tlast high on samples 4 and 8 only.
